// File: rtl/pll_rst_gen.sv
// PLL reset sequencer: pulses the PLL reset on lock timeout and holds the system in reset
// until a synchronized lock has been stable for STABLE_CYCLES clocks.
module pll_rst_gen #(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned PLL_RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [1:0] rst_state,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] retry_cnt
);

  localparam int unsigned MaxSt     = (STABLE_CYCLES > LOCK_TIMEOUT) ? STABLE_CYCLES
                                                                     : LOCK_TIMEOUT;
  localparam int unsigned MaxCycles = (MaxSt > PLL_RST_CYCLES) ? MaxSt : PLL_RST_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StStable   = 2'd1,
    StRun      = 2'd2,
    StPllRst   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sync_q;
  logic [7:0]      loss_q, loss_d;
  logic [7:0]      retry_q, retry_d;
  logic            sys_rst_n_q, pll_rst_q;
  logic            lock_s;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    retry_d = retry_q;
    unique case (state_q)
      StWaitLock: begin
        // Lock wins over a coincident timeout.
        if (lock_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StPllRst;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
        end
      end
      StPllRst: begin
        if (cnt_q == PllRstLast) begin
          state_d = StWaitLock;
          if (retry_q != 8'hff) retry_d = retry_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Reset outputs are registered from the next state so they track the state flop exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      sync_q      <= 2'b00;
      loss_q      <= 8'd0;
      retry_q     <= 8'd0;
      sys_rst_n_q <= 1'b0;
      pll_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[0], pll_lock};
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      sys_rst_n_q <= (state_d == StRun);
      pll_rst_q   <= (state_d == StPllRst);
    end
  end

  assign rst_state     = state_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign pll_rst       = pll_rst_q;
  assign lock_loss_cnt = loss_q;
  assign retry_cnt     = retry_q;

endmodule

// File: doc/pll_rst_gen.md
PLL_RST_GEN -- requirements
Module: pll_rst_gen

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: clk cycles that synchronized lock must hold before reset release; legal range >= 1.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: clk cycles allowed in WAIT_LOCK before a PLL reset retry; legal range >= 1.
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 16: width of the pll_rst pulse in clk cycles; legal range >= 1.
REQ-004 SHALL have port clk, input, 1: free-running board oscillator clock, the same clock that feeds the PLL input.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port pll_lock, input, 1: PLL lock indication, asynchronous to clk.
REQ-007 SHALL have port pll_rst, output, 1: active-high reset to the PLL RST pin.
REQ-008 SHALL have port sys_rst_n, output, 1: active-low system reset, high only in RUN.
REQ-009 SHALL have port rst_state, output, 2: current state, encoded WAIT_LOCK=0, STABLE=1, RUN=2, PLL_RST=3.
REQ-010 SHALL have port lock_loss_cnt, output, 8: count of RUN-to-WAIT_LOCK lock losses, saturating.
REQ-011 SHALL have port retry_cnt, output, 8: count of PLL reset retries, saturating.

Function
REQ-012 SHALL pass pll_lock through a 2-flop synchronizer to produce lock_s; the path has 2 cycles of latency.
REQ-013 SHALL use one shared cycle counter, cleared on every state transition and wide enough for the largest parameter.
REQ-014 WAIT_LOCK: if lock_s=1, SHALL go to STABLE; otherwise, when the counter reaches LOCK_TIMEOUT-1, SHALL go to PLL_RST; if both hold in the same cycle, STABLE wins.
REQ-015 STABLE: if lock_s=0, SHALL go to WAIT_LOCK with lock_loss_cnt unchanged; if lock_s=1 and the counter equals STABLE_CYCLES-1, SHALL go to RUN.
REQ-016 RUN: if lock_s=0, SHALL go to WAIT_LOCK and increment lock_loss_cnt, saturating at 255.
REQ-017 PLL_RST: SHALL ignore lock_s, hold pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK and increment retry_cnt, saturating at 255.
REQ-018 SHALL drive all outputs from flops: sys_rst_n=1 exactly while state=RUN, pll_rst=1 exactly while state=PLL_RST, with no combinational glitches.
REQ-019 Release latency: with edge 1 defined as the first clk edge that samples pll_lock=1, and pll_lock held high, sys_rst_n SHALL rise on edge STABLE_CYCLES+3.
REQ-020 Assertion latency: with edge 1 defined as the first edge that samples pll_lock=0 while in RUN, sys_rst_n SHALL fall on edge 3.
REQ-021 A lock glitch of any length in STABLE SHALL restart the full STABLE_CYCLES qualification from WAIT_LOCK.
REQ-022 The retry loop WAIT_LOCK -> PLL_RST -> WAIT_LOCK SHALL repeat indefinitely while lock is absent.

Reset
REQ-023 While rst_n=0, without needing a clk edge, the block SHALL hold:
- state = WAIT_LOCK
- counter and both synchronizer flops = 0
- sys_rst_n = 0, pll_rst = 0
- lock_loss_cnt = 0, retry_cnt = 0
REQ-024 Assertion of rst_n=0 at any time, including mid-RUN or mid-PLL_RST, SHALL abort immediately to the reset values; after deassertion the block SHALL start in WAIT_LOCK.

Verification
All scenarios use STABLE_CYCLES=8, LOCK_TIMEOUT=32, PLL_RST_CYCLES=4.
REQ-025 Normal lock: release rst_n, raise pll_lock sampled at edge E -> rst_state reads 1 from edge E+2 and sys_rst_n rises at edge E+10.
REQ-026 Glitch in STABLE: drop pll_lock for 3 cycles in the 4th STABLE cycle -> return to WAIT_LOCK, sys_rst_n stays 0, lock_loss_cnt=0; after relock, release occurs 11 edges later.
REQ-027 Loss in RUN: drop pll_lock sampled at edge E -> sys_rst_n=0 and rst_state=0 at edge E+2, lock_loss_cnt=1; relock releases sys_rst_n again.
REQ-028 Timeout: hold pll_lock=0 -> pll_rst high for exactly 4 cycles after every 32 WAIT_LOCK cycles; retry_cnt increments per pulse and saturates at 255 after 300 retries.
REQ-029 Async reset mid-RUN and mid-PLL_RST: pulse rst_n low between clk edges -> all outputs reach reset values before the next edge, both counters read 0, and the block restarts in WAIT_LOCK.
